// File: rtl/uart_rx_fifo_pkg.sv
// ============================================================================
// uart_pkg : shared widths and fetch-state encoding for the UART RX FIFO slice
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;
    localparam int UART_DATA_W  = 8;
    localparam int UART_STATS_W = 16;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } fetch_state_e;
endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
// ============================================================================
// uart_rx_fifo_if : first-word-fall-through byte stream (valid/ready)
// Revision        : 1.0
// ============================================================================
`default_nettype none

interface uart_rx_fifo_if;
    logic [uart_pkg::UART_DATA_W-1:0] m_data;
    logic                             m_valid;
    logic                             m_ready;

    modport master (output m_data, output m_valid, input  m_ready);
    modport slave  (input  m_data, input  m_valid, output m_ready);
endinterface

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ============================================================================
// uart_sync_fifo : single-clock FWFT byte FIFO with occupancy and level flags
// Revision       : 1.0
// ============================================================================
`default_nettype none

module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  wire logic                        rxclk,
    input  wire logic                        reset,
    input  wire logic                        flush_i,
    input  wire logic                        push_i,
    input  wire logic [UART_DATA_W-1:0]      wdata_i,
    input  wire logic                        pop_i,
    output logic      [UART_DATA_W-1:0]      rdata_o,
    output logic      [$clog2(DEPTH):0]      count_o,
    output logic                             full_o,
    output logic                             almost_full_o
);
    localparam int                   c_AW   = $clog2(DEPTH);
    localparam int                   c_CW   = c_AW + 1;
    localparam logic [c_CW-1:0]      c_FULL = c_CW'(DEPTH);
    localparam logic [c_CW-1:0]      c_AF   = c_CW'(AF_LEVEL);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]        wr_ptr_q;
    logic [c_AW-1:0]        rd_ptr_q;
    logic [c_CW-1:0]        count_q;

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge rxclk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o       = mem_q[rd_ptr_q];
    assign count_o       = count_q;
    assign full_o        = (count_q == c_FULL);
    assign almost_full_o = (count_q >= c_AF);
endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// uart_rx_fifo : drains a UART receiver into a FWFT FIFO, with optional
//                statistics counters enabled by macro UART_RX_FIFO_STATS_EN
// Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  wire logic                        rxclk,
    input  wire logic                        reset,
    input  wire logic [UART_DATA_W-1:0]      rx_data_in,
    input  wire logic                        rx_empty_in,
    output logic                             uld_rx_data,
    input  wire logic                        flush,
    uart_rx_fifo_if.master                   m_if,
    output logic      [$clog2(DEPTH):0]      count,
    output logic                             full,
    output logic                             almost_full,
    output logic      [UART_STATS_W-1:0]     rx_bytes,
    output logic      [UART_STATS_W-1:0]     stall_cycles
);
    fetch_state_e state_q;
    fetch_state_e state_d;
    logic         armed_q;
    logic         push;
    logic         pop;

    // armed_q holds off the first unload until one edge after reset release.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        uld_rx_data = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (armed_q && !rx_empty_in && !full && !flush) begin
                    uld_rx_data = 1'b1;
                    state_d     = CAPTURE;
                end
            end
            CAPTURE: begin
                push    = !flush;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop          = m_if.m_valid && m_if.m_ready;
    assign m_if.m_valid = (count != '0);

    uart_sync_fifo #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) u_fifo (
        .rxclk         (rxclk),
        .reset         (reset),
        .flush_i       (flush),
        .push_i        (push),
        .wdata_i       (rx_data_in),
        .pop_i         (pop),
        .rdata_o       (m_if.m_data),
        .count_o       (count),
        .full_o        (full),
        .almost_full_o (almost_full)
    );

`ifdef UART_RX_FIFO_STATS_EN
    logic [UART_STATS_W-1:0] rx_bytes_q;
    logic [UART_STATS_W-1:0] stall_q;

    // rx_bytes wraps naturally; stall_cycles saturates.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            rx_bytes_q <= '0;
            stall_q    <= '0;
        end else begin
            if (push) begin
                rx_bytes_q <= rx_bytes_q + 1'b1;
            end
            if ((state_q == IDLE) && !rx_empty_in && full && (stall_q != {UART_STATS_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign rx_bytes     = rx_bytes_q;
    assign stall_cycles = stall_q;
`else
    assign rx_bytes     = '0;
    assign stall_cycles = '0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// tb_uart_rx_fifo : directed table and sequence checks for uart_rx_fifo
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;
`ifdef UART_RX_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        rxclk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data_in = 8'h00;
    logic        rx_empty_in = 1'b1;
    logic        uld_rx_data;
    logic        flush = 1'b0;
    logic [4:0]  count;
    logic        full;
    logic        almost_full;
    logic [15:0] rx_bytes;
    logic [15:0] stall_cycles;

    uart_rx_fifo_if m_bus ();

    uart_rx_fifo #(.DEPTH(16), .AF_LEVEL(12)) dut (
        .rxclk        (rxclk),
        .reset        (reset),
        .rx_data_in   (rx_data_in),
        .rx_empty_in  (rx_empty_in),
        .uld_rx_data  (uld_rx_data),
        .flush        (flush),
        .m_if         (m_bus.master),
        .count        (count),
        .full         (full),
        .almost_full  (almost_full),
        .rx_bytes     (rx_bytes),
        .stall_cycles (stall_cycles)
    );

    always #5 rxclk = ~rxclk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] q  [$];
    logic [7:0] sb [$];
    int         n_uld = 0;
    int         n_pop = 0;
    logic [7:0] last_pop = 8'h00;
    logic       u_prev = 1'b0;
    logic       uart_off = 1'b0;
    logic       mr_on_cap = 1'b0;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_head;
        int         exp_count;
        logic       exp_af;
    } vec_t;
    vec_t vecs [4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One clock: sample mid-cycle, then play the UART side just after the edge.
    task automatic step();
        logic       u;
        logic [7:0] b;
        @(negedge rxclk);
        u = uld_rx_data;
        if (u) check("uld_back_to_back", u_prev, 1'b0);
        u_prev = u;
        if (m_bus.m_valid && m_bus.m_ready) begin
            if (sb.size() == 0) begin
                check("pop_unexpected", 1, 0);
            end else begin
                b = sb.pop_front();
                check("pop_data", m_bus.m_data, b);
                last_pop = b;
            end
            n_pop++;
        end
        check("full_flag", full, (count == 5'd16));
        check("af_flag", almost_full, (count >= 5'd12));
        check("valid_flag", m_bus.m_valid, (count != 5'd0));
        @(posedge rxclk);
        #1;
        if (u) begin
            n_uld++;
            if (q.size() == 0) begin
                check("uart_underrun", 1, 0);
            end else begin
                b = q.pop_front();
                rx_data_in = b;
                sb.push_back(b);
            end
        end
        if (mr_on_cap) m_bus.m_ready = u;
        rx_empty_in = (q.size() == 0) || uart_off;
        #1;
    endtask

    task automatic wait_count(input int n, input int budget, input string nm);
        int k = 0;
        while ((count != n[4:0]) && (k < budget)) begin
            step();
            k++;
        end
        check(nm, count, n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_bus.m_ready = 1'b0;
        flush = 1'b0;
        mr_on_cap = 1'b0;
        uart_off = 1'b0;
        q.delete();
        sb.delete();
        rx_empty_in = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_uld = 0;
        n_pop = 0;
        u_prev = 1'b0;
    endtask

    task automatic load(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) q.push_back(first + 8'(i));
        rx_empty_in = uart_off;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int k;
        vecs[0] = '{8'h5A, 8'hA5, 2, 1'b0};
        vecs[1] = '{8'hFF, 8'hA5, 3, 1'b0};
        vecs[2] = '{8'h00, 8'hA5, 4, 1'b0};
        vecs[3] = '{8'h3C, 8'hA5, 5, 1'b0};
        m_bus.m_ready = 1'b0;

        // Reset held with a byte waiting: no strobe, everything at rest.
        q.push_back(8'hA5);
        rx_empty_in = 1'b0;
        step();
        step();
        check("rst_uld", uld_rx_data, 0);
        check("rst_count", count, 0);
        check("rst_valid", m_bus.m_valid, 0);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_rx_bytes", rx_bytes, 0);
        check("rst_stall", stall_cycles, 0);
        check("rst_no_unload", n_uld, 0);
        reset = 1'b0;

        // Single byte after reset.
        wait_count(1, 20, "first_count");
        check("first_data", m_bus.m_data, 8'hA5);
        check("first_rx_bytes", rx_bytes, STATS ? 1 : 0);
        repeat (4) step();
        check("first_one_strobe", n_uld, 1);

        // Table: head stays put while further bytes queue behind it.
        for (int i = 0; i < 4; i++) begin
            q.push_back(vecs[i].din);
            rx_empty_in = 1'b0;
            wait_count(vecs[i].exp_count, 20, "tbl_count");
            check("tbl_head", m_bus.m_data, vecs[i].exp_head);
            check("tbl_af", almost_full, vecs[i].exp_af);
        end
        m_bus.m_ready = 1'b1;
        wait_count(0, 40, "tbl_drain");
        m_bus.m_ready = 1'b0;
        check("tbl_pops", n_pop, 5);
        check("tbl_last", last_pop, 8'h3C);

        // Fill to full, then hold a waiting byte for 10 cycles.
        do_reset();
        load(8'h00, 16);
        wait_count(16, 100, "fill16_count");
        check("fill16_full", full, 1);
        check("fill16_af", almost_full, 1);
        check("fill16_strobes", n_uld, 16);
        q.push_back(8'h10);
        rx_empty_in = 1'b0;
        repeat (10) step();
        uart_off = 1'b1;
        rx_empty_in = 1'b1;
        check("stall_no17", n_uld, 16);
        check("stall_count", stall_cycles, STATS ? 10 : 0);
        check("stall_rx_bytes", rx_bytes, STATS ? 16 : 0);
        m_bus.m_ready = 1'b1;
        wait_count(0, 60, "fill16_drain");
        m_bus.m_ready = 1'b0;
        check("fill16_pops", n_pop, 16);
        check("fill16_last", last_pop, 8'h0F);
        check("stall_hold", stall_cycles, STATS ? 10 : 0);

        // Push and pop together at count 5, across the pointer wrap.
        do_reset();
        load(8'h00, 5);
        wait_count(5, 40, "wrap_pre");
        load(8'h05, 15);
        mr_on_cap = 1'b1;
        k = 0;
        while ((q.size() != 0) && (k < 200)) begin
            step();
            check("wrap_hold", count, 5);
            k++;
        end
        step();
        check("wrap_hold_last", count, 5);
        mr_on_cap = 1'b0;
        m_bus.m_ready = 1'b1;
        wait_count(0, 40, "wrap_drain");
        m_bus.m_ready = 1'b0;
        check("wrap_pops", n_pop, 20);
        check("wrap_last", last_pop, 8'h13);
        check("wrap_rx_bytes", rx_bytes, STATS ? 20 : 0);

        // Flush while a byte is in CAPTURE.
        do_reset();
        load(8'h30, 3);
        wait_count(3, 40, "flush_pre");
        load(8'h33, 1);
        k = 0;
        while ((n_uld < 4) && (k < 20)) begin
            step();
            k++;
        end
        check("flush_reached_capture", n_uld, 4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_count", count, 0);
        check("flush_valid", m_bus.m_valid, 0);
        sb.delete();
        load(8'h40, 1);
        wait_count(1, 20, "flush_after_count");
        check("flush_after_data", m_bus.m_data, 8'h40);
        check("flush_rx_bytes", rx_bytes, STATS ? 4 : 0);

        // Reset mid-CAPTURE with count 4.
        do_reset();
        load(8'h50, 4);
        wait_count(4, 40, "rstcap_pre");
        load(8'h54, 1);
        k = 0;
        while ((n_uld < 5) && (k < 20)) begin
            step();
            k++;
        end
        check("rstcap_reached", n_uld, 5);
        reset = 1'b1;
        #1;
        check("rstcap_count", count, 0);
        check("rstcap_valid", m_bus.m_valid, 0);
        check("rstcap_full", full, 0);
        check("rstcap_af", almost_full, 0);
        check("rstcap_uld", uld_rx_data, 0);
        check("rstcap_rx_bytes", rx_bytes, 0);
        check("rstcap_stall", stall_cycles, 0);
        q.delete();
        sb.delete();
        uart_off = 1'b1;
        rx_empty_in = 1'b1;
        step();
        step();
        reset = 1'b0;
        n0 = n_uld;
        repeat (6) step();
        check("rstcap_no_unload", n_uld, n0);
        check("rstcap_count_after", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
